xor3_parity_accum: RTL and testbench
====================================

XOR3_PARITY_ACCUM -- requirements
Module: xor3_parity_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the width of the Z word per beat (range 2..32).
REQ-002 SHALL have parameter CNT_W, default 4, giving the width of the beat counter.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: synchronous reset, active-high. One clock; reset is synchronous and active-high.
REQ-005 SHALL have port IN_VALID, input, 1 bit: a Z word is presented.
REQ-006 SHALL have port IN_READY, output, 1 bit: the block accepts the word this cycle.
REQ-007 SHALL have port Z, input, WIDTH bits: the word from the upstream xor3 array.
REQ-008 SHALL have port IN_LAST, input, 1 bit: the presented word ends the current frame.
REQ-009 SHALL have port OUT_VALID, output, 1 bit: the frame result is held.
REQ-010 SHALL have port OUT_READY, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port COL_PAR, output, WIDTH bits: the bitwise XOR of all words in the frame.
REQ-012 SHALL have port ROW_PAR, output, 1 bit: the XOR of all bits of all words in the frame.
REQ-013 SHALL have port BEATS, output, CNT_W bits: the number of words accepted in the frame, saturating.
REQ-014 SHALL have port OVF, output, 1 bit: a word was accepted while BEATS was saturated.

Function
REQ-015 SHALL implement states IDLE (no beats held), ACCUM (≥1 beat held, no LAST yet), HOLD (result presented).
REQ-016 SHALL define a beat as accepted when IN_VALID=1 and IN_READY=1 at a rising CLK.
REQ-017 SHALL drive IN_READY=1 in IDLE and ACCUM, and IN_READY=0 in HOLD; there is no same-cycle bypass from HOLD.
REQ-018 SHALL, on a beat accepted in IDLE, load the accumulators with COL_PAR=Z, ROW_PAR=XOR-reduce(Z), BEATS=1 and OVF=0.
REQ-019 SHALL, on a beat accepted in ACCUM, update COL_PAR^=Z, ROW_PAR^=XOR-reduce(Z), and BEATS+=1.
REQ-020 SHALL, when BEATS=2^CNT_W-1 and a beat is accepted, hold BEATS unchanged, set OVF=1, and still fold in the parity.
REQ-021 SHALL keep OVF set until the next frame's first beat or until reset.
REQ-022 SHALL transition IDLE->ACCUM on an accepted beat with IN_LAST=0.
REQ-023 SHALL transition IDLE->HOLD or ACCUM->HOLD on an accepted beat with IN_LAST=1.
REQ-024 SHALL raise OUT_VALID in the cycle after the LAST beat is accepted (latency 1 cycle).
REQ-025 SHALL transition HOLD->IDLE when OUT_READY=1.
REQ-026 SHALL keep OUT_VALID and all result outputs stable in HOLD until OUT_READY=1.
REQ-027 SHALL handle a single-beat frame (IN_LAST=1 in IDLE) per REQ-018, giving BEATS=1.
REQ-028 SHALL hold all state in IDLE and ACCUM when IN_VALID=0.
REQ-029 SHALL ignore IN_LAST and Z when no beat is accepted.
REQ-030 SHALL present COL_PAR, ROW_PAR, BEATS and OVF as registered values that are meaningful only while OUT_VALID=1.
REQ-031 SHALL have no combinational path from any input to any output except IN_READY, which depends on state only.

Reset
REQ-032 SHALL, with RST=1 at a rising CLK, enter IDLE and clear OUT_VALID, COL_PAR, ROW_PAR, BEATS and OVF to 0.
REQ-033 SHALL drive IN_READY=1 in the cycle after reset.
REQ-034 SHALL give RST priority over any concurrent beat or OUT_READY.
REQ-035 SHALL discard any partial frame or held result on reset.

Structure
REQ-036 SHALL place the state enumeration (IDLE, ACCUM, HOLD) and the default WIDTH/CNT_W constants in the shared package xor3_parity_pkg.
REQ-037 SHALL implement the word reduction in one sub-module, xor3_fold, a combinational WIDTH-to-1 XOR tree built from 3-input XOR groups with a 2-input leaf for remainders.

Verification
REQ-038 SHALL cover the basic frame: with WIDTH=8, send beats 0x5A, 0x3C, 0xFF(LAST) with OUT_READY=1 -> one cycle later OUT_VALID=1, COL_PAR=0x99, ROW_PAR=0, BEATS=3, OVF=0.
REQ-039 SHALL cover backpressure: hold OUT_READY=0 for 5 cycles after a frame -> IN_READY=0 and outputs stable throughout; raising OUT_READY returns the block to IDLE and IN_READY=1 on the next cycle.
REQ-040 SHALL cover saturation: with CNT_W=4, send 17 beats of 0x01, the last with LAST -> BEATS=15, OVF=1, COL_PAR=0x01, ROW_PAR=1.
REQ-041 SHALL cover a single-beat frame: send 0x07 with LAST -> COL_PAR=0x07, ROW_PAR=1, BEATS=1.
REQ-042 SHALL cover reset mid-frame: after 2 beats, assert RST for 1 cycle, then send 0x80(LAST) -> COL_PAR=0x80, BEATS=1, OVF=0.
REQ-043 SHALL cover gaps: IN_VALID toggled randomly across a 4-beat frame -> the result equals the gap-free result.

Source files
------------

// File: rtl/xor3_parity_accum_pkg.sv
// Shared types and defaults for the xor3 parity accumulator.
// Holds the FSM state enumeration and the default word and counter widths.
package xor3_parity_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/xor3_parity_accum_if.sv
// Word-in / result-out handshake bundle for xor3_parity_accum.
// The accumulator uses the slave modport; the word source and result consumer use master.
interface xor3_parity_accum_if
  import xor3_parity_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
);

  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] Z;
  logic             IN_LAST;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] COL_PAR;
  logic             ROW_PAR;
  logic [CNT_W-1:0] BEATS;
  logic             OVF;

  modport slave (
    input  IN_VALID, Z, IN_LAST, OUT_READY,
    output IN_READY, OUT_VALID, COL_PAR, ROW_PAR, BEATS, OVF
  );

  modport master (
    output IN_VALID, Z, IN_LAST, OUT_READY,
    input  IN_READY, OUT_VALID, COL_PAR, ROW_PAR, BEATS, OVF
  );

endinterface

// File: rtl/xor3_parity_accum_fold.sv
// Combinational WIDTH-to-1 XOR reduction built from 3-input XOR groups.
// Each level folds groups of three bits; a 2-input leaf or pass-through takes the remainder.
module xor3_fold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] din,
  output logic             par
);

  localparam int unsigned NG = (WIDTH + 2) / 3;

  generate
    if (WIDTH == 1) begin : g_one
      assign par = din[0];
    end else if (WIDTH == 2) begin : g_two
      assign par = din[0] ^ din[1];
    end else if (WIDTH == 3) begin : g_three
      assign par = din[0] ^ din[1] ^ din[2];
    end else begin : g_tree
      logic [NG-1:0] grp;
      for (genvar g = 0; g < NG; g++) begin : g_grp
        if (3 * g + 2 < WIDTH) begin : g_x3
          assign grp[g] = din[3*g] ^ din[3*g+1] ^ din[3*g+2];
        end else if (3 * g + 1 < WIDTH) begin : g_x2
          assign grp[g] = din[3*g] ^ din[3*g+1];
        end else begin : g_x1
          assign grp[g] = din[3*g];
        end
      end
      // Next level reduces the group results; recursion ends at three or fewer bits.
      xor3_fold #(.WIDTH(NG)) u_next (
        .din (grp),
        .par (par)
      );
    end
  endgenerate

endmodule

// File: rtl/xor3_parity_accum.sv
// Frame accumulator: folds column parity, row parity and a saturating beat count
// over a framed stream of Z words, then holds the result until the consumer takes it.
module xor3_parity_accum
  import xor3_parity_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic                CLK,
  input  logic                RST,
  xor3_parity_accum_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] col_q, col_d;
  logic             row_q, row_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             ovf_q, ovf_d;
  logic             z_par;
  logic             in_ready;
  logic             accept;

  xor3_fold #(.WIDTH(WIDTH)) u_fold (
    .din (bus.Z),
    .par (z_par)
  );

  assign in_ready = (state_q != HOLD);
  assign accept   = bus.IN_VALID & in_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= 1'b0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      beats_q <= beats_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    beats_d = beats_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          col_d   = bus.Z;
          row_d   = z_par;
          beats_d = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = bus.IN_LAST ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          col_d = col_q ^ bus.Z;
          row_d = row_q ^ z_par;
          // At saturation the count freezes and OVF latches; parity keeps folding.
          if (beats_q == '1) begin
            ovf_d = 1'b1;
          end else begin
            beats_d = beats_q + CNT_W'(1);
          end
          state_d = bus.IN_LAST ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (bus.OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = (state_q == HOLD);
  assign bus.COL_PAR   = col_q;
  assign bus.ROW_PAR   = row_q;
  assign bus.BEATS     = beats_q;
  assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_xor3_parity_accum.sv
// Scoreboard bench for xor3_parity_accum: expected frame results are queued as beats
// are accepted and compared when the block hands a result to the consumer.
module tb_xor3_parity_accum;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned SAT   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [WIDTH-1:0] col;
    logic             row;
    logic [CNT_W-1:0] beats;
    logic             ovf;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;

  int unsigned n_checks   = 0;
  int unsigned n_failures = 0;

  exp_t             exp_q[$];
  logic [WIDTH-1:0] m_col;
  logic             m_row;
  int unsigned      m_cnt;

  xor3_parity_accum_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  xor3_parity_accum #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_result();
    exp_t e;
    e.col   = m_col;
    e.row   = m_row;
    e.beats = (m_cnt > SAT) ? CNT_W'(SAT) : CNT_W'(m_cnt);
    e.ovf   = (m_cnt > SAT);
    return e;
  endfunction

  task automatic model_clear();
    m_col = '0;
    m_row = 1'b0;
    m_cnt = 0;
  endtask

  // Result consumer side of the scoreboard.
  always @(negedge CLK) begin
    if (!RST && bus.OUT_VALID === 1'b1 && bus.OUT_READY === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(bus.OUT_VALID), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("col_par", 32'(bus.COL_PAR), 32'(e.col));
        check("row_par", 32'(bus.ROW_PAR), 32'(e.row));
        check("beats",   32'(bus.BEATS),   32'(e.beats));
        check("ovf",     32'(bus.OVF),     32'(e.ovf));
      end
    end
  end

  task automatic idle_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      bus.IN_VALID = 1'b0;
      bus.Z        = WIDTH'($urandom);
      bus.IN_LAST  = 1'($urandom);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_beat(input logic [WIDTH-1:0] z, input logic last, input int unsigned gap);
    int unsigned waited;
    idle_cycles(gap);
    bus.IN_VALID = 1'b1;
    bus.Z        = z;
    bus.IN_LAST  = last;
    waited = 0;
    @(negedge CLK);
    while (bus.IN_READY !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge CLK);
    end
    if (bus.IN_READY !== 1'b1) begin
      check("in_ready_timeout", 32'(bus.IN_READY), 32'd1);
    end
    @(posedge CLK);
    m_col = m_col ^ z;
    m_row = m_row ^ 1'($countones(z) & 1);
    m_cnt++;
    if (last) begin
      exp_q.push_back(model_result());
      model_clear();
    end
    #1;
    bus.IN_VALID = 1'b0;
    bus.Z        = WIDTH'($urandom);
    bus.IN_LAST  = 1'($urandom);
    if (last) begin
      @(negedge CLK);
      check("out_valid_latency", 32'(bus.OUT_VALID), 32'd1);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_reset_state();
    @(negedge CLK);
    check("rst_in_ready",  32'(bus.IN_READY),  32'd1);
    check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    check("rst_col_par",   32'(bus.COL_PAR),   32'd0);
    check("rst_row_par",   32'(bus.ROW_PAR),   32'd0);
    check("rst_beats",     32'(bus.BEATS),     32'd0);
    check("rst_ovf",       32'(bus.OVF),       32'd0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t        held;
    logic [WIDTH-1:0] w;
    model_clear();
    RST           = 1'b1;
    bus.IN_VALID  = 1'b0;
    bus.Z         = '0;
    bus.IN_LAST   = 1'b0;
    bus.OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_reset_state();

    // Basic three-beat frame: 5A ^ 3C ^ FF = 99, even bit count.
    send_beat(8'h5A, 1'b0, 0);
    send_beat(8'h3C, 1'b0, 0);
    send_beat(8'hFF, 1'b1, 0);
    check("basic_expect_col", 32'(model_result().col), 32'd0);

    // Backpressure: result must hold while OUT_READY is low.
    bus.OUT_READY = 1'b0;
    send_beat(8'h12, 1'b0, 0);
    send_beat(8'h34, 1'b1, 0);
    held = exp_q[$];
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("bp_out_valid", 32'(bus.OUT_VALID), 32'd1);
      check("bp_in_ready",  32'(bus.IN_READY),  32'd0);
      check("bp_col_par",   32'(bus.COL_PAR),   32'(held.col));
      check("bp_beats",     32'(bus.BEATS),     32'(held.beats));
    end
    @(posedge CLK);
    #1;
    bus.OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("bp_release_in_ready",  32'(bus.IN_READY),  32'd1);
    check("bp_release_out_valid", 32'(bus.OUT_VALID), 32'd0);
    @(posedge CLK);
    #1;

    // Saturation: 17 beats of 0x01.
    for (int unsigned i = 0; i < 17; i++) begin
      send_beat(8'h01, (i == 16), 0);
    end

    // Single-beat frame.
    send_beat(8'h07, 1'b1, 0);

    // Reset mid-frame discards the partial frame.
    send_beat(8'hA5, 1'b0, 0);
    send_beat(8'h0F, 1'b0, 0);
    RST = 1'b1;
    bus.IN_VALID = 1'b1;
    bus.Z        = 8'hFF;
    bus.IN_LAST  = 1'b1;
    @(posedge CLK);
    #1;
    RST          = 1'b0;
    bus.IN_VALID = 1'b0;
    model_clear();
    check_reset_state();
    send_beat(8'h80, 1'b1, 0);

    // Gapped frames: random idle cycles with junk Z / IN_LAST between beats.
    for (int unsigned f = 0; f < 3; f++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        w = WIDTH'($urandom);
        send_beat(w, (i == 3), $urandom_range(0, 3));
      end
    end

    repeat (4) @(posedge CLK);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
